pw_block_packer: RTL

PW_BLOCK_PACKER -- requirements
Module: pw_block_packer

---
 rtl/pw_pkg.sv | 18 +
 rtl/sha256_pad.sv | 27 ++
 rtl/pw_block_packer.sv | 194 +++++++++++++++++++
 3 files changed

// File: rtl/pw_pkg.sv
// Shared constants for the password block packer: SHA-256 block geometry,
// list framing bytes and the controller state encoding.
package pw_pkg;

    localparam int unsigned SHA_BLK_W   = 512;
    localparam int unsigned SHA_MAX_MSG = 55;

    localparam logic [7:0] DELIM_DEF    = 8'h0A;
    localparam logic [7:0] END_MARK_DEF = 8'h05;

    typedef logic [1:0] pw_state_t;

    localparam pw_state_t ST_IDLE  = 2'd0;
    localparam pw_state_t ST_FETCH = 2'd1;
    localparam pw_state_t ST_EMIT  = 2'd2;
    localparam pw_state_t ST_DONE  = 2'd3;

endpackage

// File: rtl/sha256_pad.sv
// Single-block SHA-256 message padding: copies len bytes, appends 0x80,
// zero-fills and places the bit length in the low 64 bits.
module sha256_pad
    import pw_pkg::*;
(
    input  logic [SHA_BLK_W-1:0] buf_data,
    input  logic [5:0]           len,
    output logic [SHA_BLK_W-1:0] blk
);

    // Byte-wise selection of message, pad marker or zero, then length field.
    always_comb begin
        blk = {SHA_BLK_W{1'b0}};
        for (int i = 0; i < 64; i++) begin
            if (6'(i) < len) begin
                blk[SHA_BLK_W-1-8*i -: 8] = buf_data[SHA_BLK_W-1-8*i -: 8];
            end else if (6'(i) == len) begin
                blk[SHA_BLK_W-1-8*i -: 8] = 8'h80;
            end else begin
                blk[SHA_BLK_W-1-8*i -: 8] = 8'h00;
            end
        end
        // len never exceeds 55 here, so bytes 56..63 are free for the length.
        blk[63:0] = {55'd0, len, 3'b000};
    end

endmodule

// File: rtl/pw_block_packer.sv
// Streams a delimited password list from byte memory and emits one padded
// SHA-256 block per password, discarding lines longer than MAX_LEN.
module pw_block_packer
    import pw_pkg::*;
#(
    parameter int unsigned ADDR_W   = 16,
    parameter int unsigned MAX_LEN  = SHA_MAX_MSG,
    parameter logic [7:0]  DELIM    = DELIM_DEF,
    parameter logic [7:0]  END_MARK = END_MARK_DEF
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 init,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic [7:0]           mem_rdata,
    output logic                 blk_valid,
    input  logic                 blk_ready,
    output logic [SHA_BLK_W-1:0] blk_data,
    output logic [5:0]           blk_len,
    output logic [31:0]          blk_idx,
    output logic                 skipped,
    output logic [31:0]          skip_count,
    output logic                 busy,
    output logic                 done,
    output logic                 err_no_end
);

    localparam logic [5:0]        OVF_LEN   = 6'(MAX_LEN + 1);
    localparam logic [5:0]        LIM_LEN   = 6'(MAX_LEN);
    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};
    localparam logic [ADDR_W-1:0] ADDR_ONE  = {{(ADDR_W-1){1'b0}}, 1'b1};

    pw_state_t              state_r;
    logic [ADDR_W-1:0]      addr_r;
    logic                   pend_r;
    logic [7:0]             hold_r;
    logic                   hold_vld_r;
    logic                   exhausted_r;
    logic                   end_pend_r;
    logic [5:0]             len_r;
    logic [SHA_BLK_W-1:0]   buf_r;
    logic                   blk_valid_r;
    logic [SHA_BLK_W-1:0]   blk_data_r;
    logic [5:0]             blk_len_r;
    logic [31:0]            blk_idx_r;
    logic                   skipped_r;
    logic [31:0]            skip_count_r;
    logic                   busy_r;
    logic                   done_r;
    logic                   err_r;

    logic                   cur_vld_s;
    logic [7:0]             cur_byte_s;
    logic                   ovf_s;
    logic                   line_ok_s;
    logic [8:0]             wr_lsb_s;
    logic [SHA_BLK_W-1:0]   pad_s;

    // A byte parked during EMIT takes priority over the RAM output.
    assign cur_vld_s  = pend_r | hold_vld_r;
    assign cur_byte_s = hold_vld_r ? hold_r : mem_rdata;
    assign ovf_s      = (len_r == OVF_LEN);
    assign line_ok_s  = (len_r != 6'd0) && !ovf_s;
    assign wr_lsb_s   = 9'd504 - {len_r, 3'b000};

    sha256_pad u_pad (
        .buf_data (buf_r),
        .len      (len_r),
        .blk      (pad_s)
    );

    assign mem_addr   = addr_r;
    assign blk_valid  = blk_valid_r;
    assign blk_data   = blk_data_r;
    assign blk_len    = blk_len_r;
    assign blk_idx    = blk_idx_r;
    assign skipped    = skipped_r;
    assign skip_count = skip_count_r;
    assign busy       = busy_r;
    assign done       = done_r;
    assign err_no_end = err_r;

    // Fetch/parse/emit controller with one-byte-per-cycle read pipeline.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r      <= ST_IDLE;
            addr_r       <= {ADDR_W{1'b0}};
            pend_r       <= 1'b0;
            hold_r       <= 8'h00;
            hold_vld_r   <= 1'b0;
            exhausted_r  <= 1'b0;
            end_pend_r   <= 1'b0;
            len_r        <= 6'd0;
            buf_r        <= {SHA_BLK_W{1'b0}};
            blk_valid_r  <= 1'b0;
            blk_data_r   <= {SHA_BLK_W{1'b0}};
            blk_len_r    <= 6'd0;
            blk_idx_r    <= 32'd0;
            skipped_r    <= 1'b0;
            skip_count_r <= 32'd0;
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            skipped_r <= 1'b0;
            case (state_r)
                ST_IDLE, ST_DONE: begin
                    if (init) begin
                        state_r      <= ST_FETCH;
                        addr_r       <= {ADDR_W{1'b0}};
                        pend_r       <= 1'b0;
                        hold_vld_r   <= 1'b0;
                        exhausted_r  <= 1'b0;
                        end_pend_r   <= 1'b0;
                        len_r        <= 6'd0;
                        blk_idx_r    <= 32'd0;
                        skip_count_r <= 32'd0;
                        busy_r       <= 1'b1;
                        done_r       <= 1'b0;
                        err_r        <= 1'b0;
                    end
                end
                ST_FETCH: begin
                    hold_vld_r <= 1'b0;
                    // The last address is read once; the counter never wraps.
                    if (!exhausted_r) begin
                        pend_r <= 1'b1;
                        if (addr_r == LAST_ADDR) begin
                            exhausted_r <= 1'b1;
                        end else begin
                            addr_r <= addr_r + ADDR_ONE;
                        end
                    end else begin
                        pend_r <= 1'b0;
                    end
                    if (cur_vld_s) begin
                        if (cur_byte_s == END_MARK || cur_byte_s == DELIM) begin
                            if (line_ok_s) begin
                                blk_data_r  <= pad_s;
                                blk_len_r   <= len_r;
                                blk_valid_r <= 1'b1;
                                end_pend_r  <= (cur_byte_s == END_MARK);
                                state_r     <= ST_EMIT;
                            end else if (ovf_s) begin
                                skipped_r    <= 1'b1;
                                skip_count_r <= skip_count_r + 32'd1;
                            end
                            len_r <= 6'd0;
                            if (cur_byte_s == END_MARK && !line_ok_s) begin
                                state_r    <= ST_DONE;
                                done_r     <= 1'b1;
                                busy_r     <= 1'b0;
                                pend_r     <= 1'b0;
                            end
                        end else if (len_r < LIM_LEN) begin
                            buf_r[wr_lsb_s +: 8] <= cur_byte_s;
                            len_r                <= len_r + 6'd1;
                        end else begin
                            len_r <= OVF_LEN;
                        end
                    end else if (exhausted_r) begin
                        state_r <= ST_DONE;
                        done_r  <= 1'b1;
                        err_r   <= 1'b1;
                        busy_r  <= 1'b0;
                    end
                end
                ST_EMIT: begin
                    if (pend_r) begin
                        hold_r     <= mem_rdata;
                        hold_vld_r <= 1'b1;
                        pend_r     <= 1'b0;
                    end
                    if (blk_ready) begin
                        blk_valid_r <= 1'b0;
                        blk_idx_r   <= blk_idx_r + 32'd1;
                        if (end_pend_r) begin
                            state_r    <= ST_DONE;
                            done_r     <= 1'b1;
                            busy_r     <= 1'b0;
                            hold_vld_r <= 1'b0;
                        end else begin
                            state_r <= ST_FETCH;
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
